// File: rtl/riscv_perf_pkg.sv
// Shared definitions for the performance counter bank.
//   - default sizing for the bank (counter count, width, event count)
//   - fixed event line indices used by the core when wiring evt[]
//   - idx_width(): index width helper that never collapses to zero bits
package riscv_perf_pkg;

  localparam int DEF_NUM_CNT = 8;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_NUM_EVT = 16;

  // Event line assignments on the evt[] bus
  localparam int EVT_CYCLE    = 0;
  localparam int EVT_INST     = 1;
  localparam int EVT_BR       = 2;
  localparam int EVT_LD       = 3;
  localparam int EVT_ST       = 4;
  localparam int EVT_BR_TAKEN = 5;
  localparam int EVT_JMP      = 6;

  // clog2 with a floor of 1 so a single-entry table still gets a real port
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One performance counter: event select mux, enable, wrapping count,
// sticky overflow flag and clear priority.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   evt          event level bus shared by all slices
//   freeze       global increment inhibit
//   clr_all      global counter/overflow clear (selection is kept)
//   cfg_load     validated configuration write targeting this slice
//   cfg_sel      event select to load
//   cfg_en       count enable to load
//   rd_clr_hit   clear-on-read targeting this slice
//   cnt          current counter value
//   ovf          sticky overflow flag
module perf_counter_slice import riscv_perf_pkg::*; #(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int NUM_EVT = DEF_NUM_EVT,
  parameter int SEL_W   = idx_width(DEF_NUM_EVT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               freeze,
  input  logic               clr_all,
  input  logic               cfg_load,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               cfg_en,
  input  logic               rd_clr_hit,
  output logic [CNT_W-1:0]   cnt,
  output logic               ovf
);

  logic [SEL_W-1:0] sel_reg;
  logic             en_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic             inc;

  // sel_reg only ever holds a value below NUM_EVT, so the index stays in range
  assign inc = en_reg & evt[sel_reg] & ~freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg <= '0;
      en_reg  <= 1'b0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      // Selection loads even when clr_all coincides; clr_all only zeroes counts
      if (cfg_load) begin
        sel_reg <= cfg_sel;
        en_reg  <= cfg_en;
      end
      if (clr_all || cfg_load) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else if (rd_clr_hit) begin
        // Keep this cycle's event so clear-on-read never drops a count
        cnt_reg <= {{(CNT_W-1){1'b0}}, inc};
        ovf_reg <= 1'b0;
      end else if (inc) begin
        cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_reg == {CNT_W{1'b1}}) begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

  assign cnt = cnt_reg;
  assign ovf = ovf_reg;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters with per-counter event select, a
// registered read port with optional clear-on-read, and an overflow IRQ.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   evt                          per-cycle event levels
//   freeze                       inhibit all increments
//   clr_all                      clear all counters and overflow flags
//   cfg_we/cfg_idx/cfg_sel/cfg_en  configuration write (clears target)
//   rd_req/rd_idx/rd_clr         read request, index, clear-on-read
//   rd_ack/rd_data/rd_ovf        read response, one cycle after rd_req
//   ovf_irq                      registered OR of all overflow flags
module perf_counter_bank import riscv_perf_pkg::*; #(
  parameter  int NUM_CNT = DEF_NUM_CNT,
  parameter  int CNT_W   = DEF_CNT_W,
  parameter  int NUM_EVT = DEF_NUM_EVT,
  localparam int IDX_W   = idx_width(NUM_CNT),
  localparam int SEL_W   = idx_width(NUM_EVT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               freeze,
  input  logic               clr_all,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               cfg_en,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_clr,
  output logic               rd_ack,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_ovf,
  output logic               ovf_irq
);

  logic [CNT_W-1:0]   cnt_arr [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_vec;
  logic               cfg_ok;

  logic               ack_reg;
  logic [CNT_W-1:0]   data_reg;
  logic               rd_ovf_reg;
  logic               irq_reg;

  logic [CNT_W-1:0]   rd_cnt_mux;
  logic               rd_ovf_mux;

  // Out-of-range index or event select makes the whole write a no-op
  assign cfg_ok = cfg_we && (int'(cfg_idx) < NUM_CNT) && (int'(cfg_sel) < NUM_EVT);

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_slice
    logic cfg_load;
    logic rd_clr_hit;

    assign cfg_load   = cfg_ok && (cfg_idx == IDX_W'(gi));
    assign rd_clr_hit = rd_req && rd_clr && (rd_idx == IDX_W'(gi));

    perf_counter_slice #(
      .CNT_W   (CNT_W),
      .NUM_EVT (NUM_EVT),
      .SEL_W   (SEL_W)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .evt        (evt),
      .freeze     (freeze),
      .clr_all    (clr_all),
      .cfg_load   (cfg_load),
      .cfg_sel    (cfg_sel),
      .cfg_en     (cfg_en),
      .rd_clr_hit (rd_clr_hit),
      .cnt        (cnt_arr[gi]),
      .ovf        (ovf_vec[gi])
    );
  end

  // Decoded read mux; an index with no matching counter falls through to 0
  always_comb begin
    rd_cnt_mux = '0;
    rd_ovf_mux = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_cnt_mux = cnt_arr[i];
        rd_ovf_mux = ovf_vec[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_reg    <= 1'b0;
      data_reg   <= '0;
      rd_ovf_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      ack_reg <= rd_req;
      // Response captures the pre-edge value; it holds between reads
      if (rd_req) begin
        data_reg   <= rd_cnt_mux;
        rd_ovf_reg <= rd_ovf_mux;
      end
      irq_reg <= |ovf_vec;
    end
  end

  assign rd_ack  = ack_reg;
  assign rd_data = data_reg;
  assign rd_ovf  = rd_ovf_reg;
  assign ovf_irq = irq_reg;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank (6 counters, 8-bit, 12 events).
module tb_perf_counter_bank;

  localparam int NUM_CNT = 6;
  localparam int CNT_W   = 8;
  localparam int NUM_EVT = 12;

  logic         clk;
  logic         rst;
  logic [11:0]  evt;
  logic         freeze;
  logic         clr_all;
  logic         cfg_we;
  logic [2:0]   cfg_idx;
  logic [3:0]   cfg_sel;
  logic         cfg_en;
  logic         rd_req;
  logic [2:0]   rd_idx;
  logic         rd_clr;
  logic         rd_ack;
  logic [7:0]   rd_data;
  logic         rd_ovf;
  logic         ovf_irq;

  int total = 0;
  int bad   = 0;

  perf_counter_bank #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W),
    .NUM_EVT (NUM_EVT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .evt     (evt),
    .freeze  (freeze),
    .clr_all (clr_all),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_sel (cfg_sel),
    .cfg_en  (cfg_en),
    .rd_req  (rd_req),
    .rd_idx  (rd_idx),
    .rd_clr  (rd_clr),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .rd_ovf  (rd_ovf),
    .ovf_irq (ovf_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [2:0] idx, input logic clr,
                         input logic [7:0] exp_d, input logic exp_o);
    rd_req = 1'b1;
    rd_idx = idx;
    rd_clr = clr;
    tick();
    rd_req = 1'b0;
    rd_clr = 1'b0;
    $display("read %s idx=%0d clr=%0b ack=%0b data=%0d ovf=%0b irq=%0b",
             tag, idx, clr, rd_ack, rd_data, rd_ovf, ovf_irq);
    chk({tag, "_ack"}, rd_ack, 1);
    chk({tag, "_data"}, rd_data, exp_d);
    chk({tag, "_ovf"}, rd_ovf, exp_o);
  endtask

  task automatic do_cfg(input logic [2:0] idx, input logic [3:0] sel, input logic en);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_sel = sel;
    cfg_en  = en;
    tick();
    cfg_we  = 1'b0;
    $display("cfg idx=%0d sel=%0d en=%0b", idx, sel, en);
  endtask

  initial begin
    rst = 1'b1; evt = '0; freeze = 1'b0; clr_all = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_en = 1'b0;
    rd_req = 1'b0; rd_idx = '0; rd_clr = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ack", rd_ack, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ovf", rd_ovf, 0);
    chk("rst_irq", ovf_irq, 0);
    rst = 1'b0;

    // Cycle counter: 100 counting edges before the read edge
    evt[0] = 1'b1;
    do_cfg(3'd0, 4'd0, 1'b1);
    repeat (100) tick();
    do_read("cyc100", 3'd0, 1'b0, 8'd100, 1'b0);
    tick();
    chk("hold_ack", rd_ack, 0);
    chk("hold_data", rd_data, 100);

    // Freeze: counter sits at 102 through 10 frozen cycles
    freeze = 1'b1;
    repeat (10) tick();
    do_read("frozen", 3'd0, 1'b0, 8'd102, 1'b0);
    freeze = 1'b0;
    do_read("unfrozen", 3'd0, 1'b0, 8'd102, 1'b0);

    // clr_all together with cfg_we: counter cleared, new select (event 1) live
    clr_all = 1'b1;
    do_cfg(3'd0, 4'd1, 1'b1);
    clr_all = 1'b0;
    repeat (3) tick();
    do_read("clr_cfg", 3'd0, 1'b0, 8'd0, 1'b0);
    evt[1] = 1'b1;
    repeat (5) tick();
    evt[1] = 1'b0;
    do_read("new_sel", 3'd0, 1'b0, 8'd5, 1'b0);
    // clr_all alone keeps the selection
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    evt[1] = 1'b1;
    repeat (3) tick();
    evt[1] = 1'b0;
    do_read("clr_keep_sel", 3'd0, 1'b0, 8'd3, 1'b0);

    // Clear-on-read every cycle on counter 2 with event 3 held high
    evt[3] = 1'b1;
    do_cfg(3'd2, 4'd3, 1'b1);
    do_read("rdclr_first", 3'd2, 1'b1, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      do_read("rdclr_loop", 3'd2, 1'b1, 8'd1, 1'b0);
    end
    // Config of counter 1 in the same cycle as a clear-read of counter 2
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_sel = 4'd3; cfg_en = 1'b1;
    do_read("rdclr_with_cfg", 3'd2, 1'b1, 8'd1, 1'b0);
    cfg_we = 1'b0;
    do_read("c1_after_cfg", 3'd1, 1'b0, 8'd0, 1'b0);
    do_read("c1_count", 3'd1, 1'b0, 8'd1, 1'b0);
    evt[3] = 1'b0;
    // Event select out of range is ignored: counter 1 keeps its count
    do_cfg(3'd1, 4'd12, 1'b0);
    do_read("bad_sel", 3'd1, 1'b0, 8'd2, 1'b0);

    // Wrap and overflow on counter 3 (event 4)
    do_cfg(3'd3, 4'd4, 1'b1);
    evt[4] = 1'b1;
    repeat (255) tick();
    evt[4] = 1'b0;
    do_read("pre_wrap", 3'd3, 1'b0, 8'd255, 1'b0);
    chk("irq_pre", ovf_irq, 0);
    evt[4] = 1'b1;
    tick();
    evt[4] = 1'b0;
    chk("irq_lag", ovf_irq, 0);
    do_read("wrap", 3'd3, 1'b0, 8'd0, 1'b1);
    chk("irq_set", ovf_irq, 1);
    do_read("ovf_rdclr", 3'd3, 1'b1, 8'd0, 1'b1);
    chk("irq_still", ovf_irq, 1);
    tick();
    chk("irq_fall", ovf_irq, 0);

    // Out-of-range read right after a nonzero read
    do_read("c1_again", 3'd1, 1'b0, 8'd2, 1'b0);
    do_read("oob", 3'd6, 1'b0, 8'd0, 1'b0);

    // Reset coinciding with a read request suppresses the ack
    do_read("c0_pre_rst", 3'd0, 1'b0, 8'd3, 1'b0);
    rst = 1'b1;
    rd_req = 1'b1;
    rd_idx = 3'd0;
    tick();
    rd_req = 1'b0;
    chk("rstrd_ack", rd_ack, 0);
    chk("rstrd_data", rd_data, 0);
    chk("rstrd_ovf", rd_ovf, 0);
    chk("rstrd_irq", ovf_irq, 0);
    rst = 1'b0;
    repeat (3) tick();
    do_read("c0_post_rst", 3'd0, 1'b0, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 The block SHALL have parameter NUM_CNT, default 8, meaning number of counters (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning counter width in bits (8..64).
REQ-003 The block SHALL have parameter NUM_EVT, default 16, meaning number of event inputs (2..64); IDX_W = clog2(NUM_CNT) and SEL_W = clog2(NUM_EVT) are derived.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 evt  in  NUM_EVT  per-cycle event levels; bit k high means one occurrence of event k this cycle.
REQ-007 freeze  in  1  while high, no counter increments.
REQ-008 clr_all  in  1  clears all counters and overflow flags.
REQ-009 cfg_we  in  1  configuration write strobe.
REQ-010 cfg_idx  in  IDX_W  counter being configured.
REQ-011 cfg_sel  in  SEL_W  event select for that counter.
REQ-012 cfg_en  in  1  count enable for that counter.
REQ-013 rd_req  in  1  read request.
REQ-014 rd_idx  in  IDX_W  counter to read.
REQ-015 rd_clr  in  1  clear-on-read qualifier for rd_req.
REQ-016 rd_ack  out  1  read data valid, single-cycle pulse.
REQ-017 rd_data  out  CNT_W  counter value returned.
REQ-018 rd_ovf  out  1  overflow flag of the counter read.
REQ-019 ovf_irq  out  1  high while any overflow flag is set.

Function
REQ-020 Counter i SHALL increment by 1 in a cycle where en[i]=1, evt[sel[i]]=1, freeze=0, and no clear/config targets it.
REQ-021 Increment from 2^CNT_W-1 SHALL wrap to 0 and set sticky ovf[i] in the same edge.
REQ-022 cfg_we SHALL load sel[cfg_idx] and en[cfg_idx], and clear that counter and ovf flag; the new selection takes effect from the next cycle.
REQ-023 cfg_idx >= NUM_CNT or cfg_sel >= NUM_EVT SHALL be ignored (no state change).
REQ-024 rd_req in cycle N SHALL produce rd_ack=1 in cycle N+1, with rd_data/rd_ovf equal to the values held before the cycle-N edge; one read per cycle and back-to-back reads SHALL be supported.
REQ-025 rd_idx >= NUM_CNT SHALL return rd_ack=1, rd_data=0, rd_ovf=0.
REQ-026 rd_req with rd_clr=1 SHALL load the counter with the cycle-N increment (0 or 1) and clear ovf, losing no events.
REQ-027 rd_data and rd_ovf SHALL hold their value when rd_ack=0.
REQ-028 Priority per counter SHALL be: rst > clr_all > cfg_we > rd_clr > increment.
REQ-029 clr_all SHALL not alter sel/en.
REQ-030 ovf_irq SHALL be registered: it rises the cycle after any ovf bit sets and falls the cycle after the last one clears.
REQ-031 Reads and configs targeting different counters in the same cycle SHALL both complete.

Reset
REQ-032 On rst, all counters, ovf flags, sel and en SHALL be 0, and rd_ack, rd_data, rd_ovf, ovf_irq SHALL be 0 from the next cycle.
REQ-033 rst asserted with a read in flight SHALL suppress that rd_ack.

Structure
REQ-034 A shared package riscv_perf_pkg SHALL hold the parameter defaults and event index constants: EVT_CYCLE=0, EVT_INST=1, EVT_BR=2, EVT_LD=3, EVT_ST=4, EVT_BR_TAKEN=5, EVT_JMP=6.
REQ-035 One sub-module, perf_counter_slice, SHALL implement a single counter: select mux, wrap, sticky ovf and clear priority, replicated NUM_CNT times.

Verification
REQ-036 Cfg counter 0 sel=EVT_CYCLE en=1, run 100 cycles, read idx 0 -> rd_ack next cycle, rd_data=100 (count up to the read edge).
REQ-037 CNT_W=8, preload by counting 255 events, then 1 more -> counter=0, rd_ovf=1, ovf_irq=1 one cycle later.
REQ-038 evt[3] held high, rd_req idx=2 rd_clr=1 each cycle -> every rd_data=1, no event lost.
REQ-039 freeze=1 for 10 cycles amid EVT_CYCLE counting -> counter unchanged over those cycles; clr_all with simultaneous cfg_we -> counter 0, new sel applied.
REQ-040 rst during cycle after rd_req -> rd_ack stays 0; all outputs 0; reads idx=NUM_CNT -> rd_data=0 with rd_ack=1.
